// File: rtl/boot_ram_arb_if.sv
// Bundle of the core/loader requester ports, RAM port B and status signals
// shared between the boot RAM arbiter and its neighbours.
interface boot_ram_arb_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ADDR_W = 5
);
  logic              core_req;
  logic              core_we;
  logic [XLEN-1:0]   core_addr;
  logic [XLEN-1:0]   core_wdata;
  logic              core_gnt;
  logic              core_rvalid;
  logic [XLEN-1:0]   core_rdata;

  logic              ldr_req;
  logic              ldr_we;
  logic [XLEN-1:0]   ldr_addr;
  logic [XLEN-1:0]   ldr_wdata;
  logic              ldr_gnt;
  logic              ldr_rvalid;
  logic [XLEN-1:0]   ldr_rdata;

  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [XLEN-1:0]   ram_wdata;
  logic [XLEN-1:0]   ram_rdata;

  logic [7:0]        err_cnt;
  logic              busy;

  modport slave (
    input  core_req, core_we, core_addr, core_wdata,
    output core_gnt, core_rvalid, core_rdata,
    input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
    output ldr_gnt, ldr_rvalid, ldr_rdata,
    output ram_en, ram_we, ram_addr, ram_wdata,
    input  ram_rdata,
    output err_cnt, busy
  );

  modport master (
    output core_req, core_we, core_addr, core_wdata,
    input  core_gnt, core_rvalid, core_rdata,
    output ldr_req, ldr_we, ldr_addr, ldr_wdata,
    input  ldr_gnt, ldr_rvalid, ldr_rdata,
    input  ram_en, ram_we, ram_addr, ram_wdata,
    output ram_rdata,
    input  err_cnt, busy
  );
endinterface

// File: rtl/boot_ram_arb.sv
// Two-requester arbiter for the boot RAM port B: core has priority, loader is
// promoted after MAX_WAIT starved cycles; reads return two cycles after grant.
module boot_ram_arb #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  boot_ram_arb_if.slave bus
);
  localparam int unsigned WAIT_W   = 4;
  localparam int unsigned HI_SHIFT = ADDR_W + 2;
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0] wait_cnt;
  logic              ldr_wins_c;
  logic              core_gnt_c;
  logic              ldr_gnt_c;
  logic              any_gnt_c;
  logic              sel_we_c;
  logic              sel_oor_c;
  logic [XLEN-1:0]   sel_addr_c;
  logic [XLEN-1:0]   sel_wdata_c;

  logic              ram_en_q;
  logic              ram_we_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [XLEN-1:0]   ram_wdata_q;
  logic [7:0]        err_cnt_q;

  // Tag pipeline: s1 aligns with the RAM command, s2 with the RAM read data.
  logic              s1_rd, s1_ldr, s1_oor;
  logic              s2_rd, s2_ldr, s2_oor;

  logic              core_rvalid_c;
  logic              ldr_rvalid_c;
  logic [XLEN-1:0]   rd_word_c;
  logic [XLEN-1:0]   core_rdata_q;
  logic [XLEN-1:0]   ldr_rdata_q;

  // Grant selection and command mux; grants are forced low during reset.
  always_comb begin
    ldr_wins_c  = 1'b0;
    core_gnt_c  = 1'b0;
    ldr_gnt_c   = 1'b0;
    any_gnt_c   = 1'b0;
    sel_we_c    = 1'b0;
    sel_addr_c  = '0;
    sel_wdata_c = '0;
    sel_oor_c   = 1'b0;

    ldr_wins_c = bus.ldr_req && (!bus.core_req || (wait_cnt == WAIT_LIMIT));
    core_gnt_c = rst_n && bus.core_req && !ldr_wins_c;
    ldr_gnt_c  = rst_n && ldr_wins_c;
    any_gnt_c  = core_gnt_c || ldr_gnt_c;

    if (ldr_gnt_c) begin
      sel_we_c    = bus.ldr_we;
      sel_addr_c  = bus.ldr_addr;
      sel_wdata_c = bus.ldr_wdata;
    end else begin
      sel_we_c    = bus.core_we;
      sel_addr_c  = bus.core_addr;
      sel_wdata_c = bus.core_wdata;
    end
    sel_oor_c = |(sel_addr_c >> HI_SHIFT);
  end

  // Loader starvation counter, saturating at the promotion threshold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (bus.ldr_req && !ldr_gnt_c) begin
      if (wait_cnt != WAIT_LIMIT) wait_cnt <= wait_cnt + WAIT_W'(1);
    end else begin
      wait_cnt <= '0;
    end
  end

  // Registered RAM command plus out-of-range accounting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      ram_en_q <= any_gnt_c && !sel_oor_c;
      ram_we_q <= any_gnt_c && !sel_oor_c && sel_we_c;
      if (any_gnt_c) begin
        ram_addr_q  <= sel_addr_c[ADDR_W+1:2];
        ram_wdata_q <= sel_wdata_c;
      end
      if (any_gnt_c && sel_oor_c && (err_cnt_q != 8'hFF)) begin
        err_cnt_q <= err_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_rd  <= 1'b0;
      s1_ldr <= 1'b0;
      s1_oor <= 1'b0;
      s2_rd  <= 1'b0;
      s2_ldr <= 1'b0;
      s2_oor <= 1'b0;
    end else begin
      s1_rd  <= any_gnt_c && !sel_we_c;
      s1_ldr <= ldr_gnt_c;
      s1_oor <= sel_oor_c;
      s2_rd  <= s1_rd;
      s2_ldr <= s1_ldr;
      s2_oor <= s1_oor;
    end
  end

  always_comb begin
    core_rvalid_c = s2_rd && !s2_ldr;
    ldr_rvalid_c  = s2_rd && s2_ldr;
    rd_word_c     = s2_oor ? '0 : bus.ram_rdata;
  end

  // Read data holders keep the last returned word between responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_rdata_q <= '0;
      ldr_rdata_q  <= '0;
    end else begin
      if (core_rvalid_c) core_rdata_q <= rd_word_c;
      if (ldr_rvalid_c)  ldr_rdata_q  <= rd_word_c;
    end
  end

  assign bus.core_gnt    = core_gnt_c;
  assign bus.ldr_gnt     = ldr_gnt_c;
  assign bus.core_rvalid = core_rvalid_c;
  assign bus.ldr_rvalid  = ldr_rvalid_c;
  assign bus.core_rdata  = core_rvalid_c ? rd_word_c : core_rdata_q;
  assign bus.ldr_rdata   = ldr_rvalid_c  ? rd_word_c : ldr_rdata_q;
  assign bus.ram_en      = ram_en_q;
  assign bus.ram_we      = ram_we_q;
  assign bus.ram_addr    = ram_addr_q;
  assign bus.ram_wdata   = ram_wdata_q;
  assign bus.err_cnt     = err_cnt_q;
  assign bus.busy        = s1_rd || s2_rd;

endmodule

// File: tb/tb_boot_ram_arb.sv
// Directed bench for boot_ram_arb with a 32-word synchronous RAM model
// preloaded with 0xA500_0000 + word index.
module tb_boot_ram_arb;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned ADDR_W = 5;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  logic [XLEN-1:0] mem [32];

  boot_ram_arb_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) bus ();

  boot_ram_arb #(.XLEN(XLEN), .ADDR_W(ADDR_W), .MAX_WAIT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (bus.ram_en) begin
      if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
      else            bus.ram_rdata     <= mem[bus.ram_addr];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_core(input logic req, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata);
    bus.core_req = req; bus.core_we = we; bus.core_addr = addr; bus.core_wdata = wdata;
  endtask

  task automatic set_ldr(input logic req, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata);
    bus.ldr_req = req; bus.ldr_we = we; bus.ldr_addr = addr; bus.ldr_wdata = wdata;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_core(1'b1, 1'b0, 32'h10, 32'h0);
    set_ldr(1'b1, 1'b0, 32'h4, 32'h0);
    #2;
    tests++; if (bus.core_gnt !== 1'b0 || bus.ldr_gnt !== 1'b0) begin fails++;
      $display("FAIL rst_gnt: got core=%b ldr=%b expected 0/0", bus.core_gnt, bus.ldr_gnt); end
    step();
    tests++; if (bus.ram_en !== 1'b0 || bus.ram_we !== 1'b0 || bus.ram_addr !== 5'd0) begin fails++;
      $display("FAIL rst_ram: got en=%b we=%b addr=%h expected 0/0/0", bus.ram_en, bus.ram_we, bus.ram_addr); end
    tests++; if (bus.err_cnt !== 8'd0 || bus.busy !== 1'b0) begin fails++;
      $display("FAIL rst_status: got err=%0d busy=%b expected 0/0", bus.err_cnt, bus.busy); end
    tests++; if (bus.core_rvalid !== 1'b0 || bus.ldr_rvalid !== 1'b0 ||
                 bus.core_rdata !== 32'h0 || bus.ldr_rdata !== 32'h0) begin fails++;
      $display("FAIL rst_rsp: got rv=%b/%b rd=%h/%h expected 0", bus.core_rvalid, bus.ldr_rvalid,
               bus.core_rdata, bus.ldr_rdata); end
    set_ldr(1'b0, 1'b0, 32'h0, 32'h0);
    rst_n = 1'b1;
  endtask

  // Core read of 0x10 on the first edge after reset release.
  task automatic test_core_read();
    #1;
    tests++; if (bus.core_gnt !== 1'b1 || bus.ldr_gnt !== 1'b0) begin fails++;
      $display("FAIL rd_gnt: got core=%b ldr=%b expected 1/0", bus.core_gnt, bus.ldr_gnt); end
    step();
    set_core(1'b0, 1'b0, 32'h0, 32'h0);
    tests++; if (bus.ram_en !== 1'b1 || bus.ram_we !== 1'b0 || bus.ram_addr !== 5'd4) begin fails++;
      $display("FAIL rd_cmd: got en=%b we=%b addr=%0d expected 1/0/4", bus.ram_en, bus.ram_we, bus.ram_addr); end
    tests++; if (bus.busy !== 1'b1 || bus.core_rvalid !== 1'b0) begin fails++;
      $display("FAIL rd_n1: got busy=%b rv=%b expected 1/0", bus.busy, bus.core_rvalid); end
    step();
    tests++; if (bus.core_rvalid !== 1'b1 || bus.core_rdata !== 32'hA500_0004) begin fails++;
      $display("FAIL rd_data: got rv=%b rd=%h expected 1/a5000004", bus.core_rvalid, bus.core_rdata); end
    tests++; if (bus.ldr_rvalid !== 1'b0 || bus.ram_en !== 1'b0 || bus.busy !== 1'b1) begin fails++;
      $display("FAIL rd_n2: got ldr_rv=%b en=%b busy=%b expected 0/0/1", bus.ldr_rvalid, bus.ram_en, bus.busy); end
    step();
    tests++; if (bus.core_rvalid !== 1'b0 || bus.core_rdata !== 32'hA500_0004 || bus.busy !== 1'b0) begin fails++;
      $display("FAIL rd_hold: got rv=%b rd=%h busy=%b expected 0/a5000004/0", bus.core_rvalid,
               bus.core_rdata, bus.busy); end
  endtask

  // Both requesters held: four core grants, one loader grant, repeating.
  task automatic test_back_to_back();
    logic exp_ldr, exp_ldr_rv;
    set_core(1'b1, 1'b0, 32'h0, 32'h0);
    set_ldr(1'b1, 1'b0, 32'h4, 32'h0);
    for (int i = 0; i < 12; i++) begin
      #1;
      exp_ldr = ((i % 5) == 4);
      tests++; if (bus.ldr_gnt !== exp_ldr || bus.core_gnt !== !exp_ldr) begin fails++;
        $display("FAIL b2b_gnt[%0d]: got core=%b ldr=%b expected %b/%b", i, bus.core_gnt,
                 bus.ldr_gnt, !exp_ldr, exp_ldr); end
      if (i >= 2) begin
        exp_ldr_rv = (((i - 2) % 5) == 4);
        tests++; if (bus.ldr_rvalid !== exp_ldr_rv || bus.core_rvalid !== !exp_ldr_rv ||
                     (exp_ldr_rv && bus.ldr_rdata !== 32'hA500_0001) ||
                     (!exp_ldr_rv && bus.core_rdata !== 32'hA500_0000)) begin fails++;
          $display("FAIL b2b_rsp[%0d]: got rv=%b/%b rd=%h/%h expected rv=%b/%b", i, bus.core_rvalid,
                   bus.ldr_rvalid, bus.core_rdata, bus.ldr_rdata, !exp_ldr_rv, exp_ldr_rv); end
      end
      step();
    end
    set_core(1'b0, 1'b0, 32'h0, 32'h0);
    set_ldr(1'b0, 1'b0, 32'h0, 32'h0);
    step(); step(); step();
  endtask

  // Loader write of word 2 immediately followed by a core read of it.
  task automatic test_write_then_read();
    set_ldr(1'b1, 1'b1, 32'h8, 32'hDEAD_BEEF);
    #1;
    tests++; if (bus.ldr_gnt !== 1'b1 || bus.core_gnt !== 1'b0) begin fails++;
      $display("FAIL wr_gnt: got ldr=%b core=%b expected 1/0", bus.ldr_gnt, bus.core_gnt); end
    step();
    set_ldr(1'b0, 1'b0, 32'h0, 32'h0);
    set_core(1'b1, 1'b0, 32'h8, 32'h0);
    #1;
    tests++; if (bus.ram_en !== 1'b1 || bus.ram_we !== 1'b1 || bus.ram_addr !== 5'd2 ||
                 bus.ram_wdata !== 32'hDEAD_BEEF) begin fails++;
      $display("FAIL wr_cmd: got en=%b we=%b addr=%0d wd=%h expected 1/1/2/deadbeef", bus.ram_en,
               bus.ram_we, bus.ram_addr, bus.ram_wdata); end
    tests++; if (bus.core_gnt !== 1'b1 || bus.busy !== 1'b0) begin fails++;
      $display("FAIL wr_rd_gnt: got gnt=%b busy=%b expected 1/0", bus.core_gnt, bus.busy); end
    step();
    set_core(1'b0, 1'b0, 32'h0, 32'h0);
    tests++; if (bus.ram_en !== 1'b1 || bus.ram_we !== 1'b0 || bus.ram_addr !== 5'd2 ||
                 bus.ldr_rvalid !== 1'b0) begin fails++;
      $display("FAIL wr_rd_cmd: got en=%b we=%b addr=%0d ldr_rv=%b expected 1/0/2/0", bus.ram_en,
               bus.ram_we, bus.ram_addr, bus.ldr_rvalid); end
    step();
    tests++; if (bus.core_rvalid !== 1'b1 || bus.core_rdata !== 32'hDEAD_BEEF || bus.ldr_rvalid !== 1'b0) begin fails++;
      $display("FAIL wr_rd_data: got rv=%b rd=%h ldr_rv=%b expected 1/deadbeef/0", bus.core_rvalid,
               bus.core_rdata, bus.ldr_rvalid); end
    step();
  endtask

  // Out-of-range reads return zero, never touch the RAM and saturate err_cnt.
  task automatic test_out_of_range();
    logic saw_en;
    saw_en = 1'b0;
    set_core(1'b1, 1'b0, 32'h100, 32'h0);
    #1;
    tests++; if (bus.core_gnt !== 1'b1) begin fails++;
      $display("FAIL oor_gnt: got %b expected 1", bus.core_gnt); end
    step();
    tests++; if (bus.ram_en !== 1'b0 || bus.err_cnt !== 8'd1 || bus.busy !== 1'b1) begin fails++;
      $display("FAIL oor_cmd: got en=%b err=%0d busy=%b expected 0/1/1", bus.ram_en, bus.err_cnt, bus.busy); end
    step();
    tests++; if (bus.core_rvalid !== 1'b1 || bus.core_rdata !== 32'h0 || bus.err_cnt !== 8'd2) begin fails++;
      $display("FAIL oor_data: got rv=%b rd=%h err=%0d expected 1/0/2", bus.core_rvalid,
               bus.core_rdata, bus.err_cnt); end
    for (int k = 0; k < 298; k++) begin
      step();
      if (bus.ram_en) saw_en = 1'b1;
      if (k == 197) begin
        tests++; if (bus.err_cnt !== 8'd200) begin fails++;
          $display("FAIL oor_cnt200: got %0d expected 200", bus.err_cnt); end
      end
    end
    set_core(1'b0, 1'b0, 32'h0, 32'h0);
    tests++; if (bus.err_cnt !== 8'd255 || saw_en !== 1'b0) begin fails++;
      $display("FAIL oor_sat: got err=%0d ram_en_seen=%b expected 255/0", bus.err_cnt, saw_en); end
    step(); step();
    set_ldr(1'b1, 1'b1, 32'h80, 32'h1234_5678);
    #1;
    tests++; if (bus.ldr_gnt !== 1'b1) begin fails++;
      $display("FAIL oor_wr_gnt: got %b expected 1", bus.ldr_gnt); end
    step();
    set_ldr(1'b0, 1'b0, 32'h0, 32'h0);
    tests++; if (bus.ram_en !== 1'b0 || bus.ram_we !== 1'b0 || bus.err_cnt !== 8'd255) begin fails++;
      $display("FAIL oor_wr: got en=%b we=%b err=%0d expected 0/0/255", bus.ram_en, bus.ram_we, bus.err_cnt); end
    step();
    tests++; if (bus.ldr_rvalid !== 1'b0 || bus.core_rvalid !== 1'b0) begin fails++;
      $display("FAIL oor_wr_rsp: got rv=%b/%b expected 0/0", bus.core_rvalid, bus.ldr_rvalid); end
    step();
  endtask

  // Reset while a read is in flight drops it and clears everything at once.
  task automatic test_reset_inflight();
    set_core(1'b1, 1'b0, 32'h10, 32'h0);
    step();
    set_core(1'b0, 1'b0, 32'h0, 32'h0);
    tests++; if (bus.busy !== 1'b1 || bus.ram_en !== 1'b1) begin fails++;
      $display("FAIL rsti_pre: got busy=%b en=%b expected 1/1", bus.busy, bus.ram_en); end
    #1 rst_n = 1'b0;
    #1;
    tests++; if (bus.busy !== 1'b0 || bus.ram_en !== 1'b0 || bus.err_cnt !== 8'd0 ||
                 bus.core_rdata !== 32'h0) begin fails++;
      $display("FAIL rsti_async: got busy=%b en=%b err=%0d rd=%h expected 0/0/0/0", bus.busy,
               bus.ram_en, bus.err_cnt, bus.core_rdata); end
    step(); step();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      tests++; if (bus.core_rvalid !== 1'b0 || bus.busy !== 1'b0 || bus.err_cnt !== 8'd0) begin fails++;
        $display("FAIL rsti_post[%0d]: got rv=%b busy=%b err=%0d expected 0/0/0", k,
                 bus.core_rvalid, bus.busy, bus.err_cnt); end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    for (int i = 0; i < 32; i++) mem[i] = 32'hA500_0000 + 32'(i);
    bus.ram_rdata = '0;
    test_reset();
    test_core_read();
    test_back_to_back();
    test_write_then_read();
    test_out_of_range();
    test_reset_inflight();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/boot_ram_arb.md
BOOT_RAM_ARB -- requirements
Module: boot_ram_arb

Interface
REQ-001 SHALL have parameter XLEN, default 32: data and address width of both requester ports.
REQ-002 SHALL have parameter ADDR_W, default 5: RAM port B word-address width.
REQ-003 SHALL have parameter MAX_WAIT, default 4: loader starvation limit in cycles (1..15).
REQ-004 SHALL have ports: clk  in  1  system clock; rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports: core_req  in  1  core access request; core_we  in  1  1=write, 0=read; core_addr  in  XLEN  byte address; core_wdata  in  XLEN  write data.
REQ-006 SHALL have ports: core_gnt  out  1  request accepted this cycle; core_rvalid  out  1  read data valid; core_rdata  out  XLEN  read data.
REQ-007 SHALL have ports: ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_gnt, ldr_rvalid, ldr_rdata, with the same directions, widths and meaning as the core_* ports, for the boot loader.
REQ-008 SHALL have ports: ram_en  out  1  port B enable; ram_we  out  1  port B write; ram_addr  out  ADDR_W  word address; ram_wdata  out  XLEN  write data; ram_rdata  in  XLEN  port B read data (1-cycle synchronous).
REQ-009 SHALL have ports: err_cnt  out  8  saturating out-of-range access count; busy  out  1  a RAM read is in flight.

Function
REQ-010 SHALL arbitrate combinationally each cycle; at most one of core_gnt/ldr_gnt is high, and a gnt is high only when its req is high.
REQ-011 SHALL give the core fixed priority, except when the wait counter equals MAX_WAIT, in which case the loader wins.
REQ-012 SHALL increment the 4-bit wait counter (saturating at MAX_WAIT) each cycle that ldr_req=1 and ldr_gnt=0; SHALL clear it on ldr_gnt=1 or ldr_req=0.
REQ-013 SHALL register the granted command: if gnt in cycle N, ram_en=1, ram_we=we and ram_addr=addr[ADDR_W+1:2] SHALL be presented in cycle N+1, with ram_wdata=wdata; with no grant, ram_en=0 and ram_we=0 in N+1.
REQ-014 SHALL ignore addr[1:0] (word access only).
REQ-015 SHALL treat an access as out-of-range when any addr bit above ADDR_W+1 is nonzero: it is granted normally, ram_en stays 0, err_cnt increments (saturating at 255), and writes are dropped.
REQ-016 SHALL, for a granted read in cycle N, pulse the owner's rvalid in cycle N+2 with rdata=ram_rdata (in-range) or 0 (out-of-range); the non-owner's rvalid SHALL stay 0.
REQ-017 SHALL track owner/read/range through a 2-stage tag pipeline, accepting back-to-back grants every cycle with no bubbles.
REQ-018 SHALL hold core_rdata/ldr_rdata at their last value when rvalid=0.
REQ-019 SHALL drive busy=1 whenever either pipeline stage holds a read.
REQ-020 SHALL never grant a write and report rvalid for it.

Reset
REQ-021 SHALL, on rst_n=0, immediately clear ram_en, ram_we, ram_addr, ram_wdata, both rvalid, both rdata, err_cnt, the wait counter, the tag pipeline and busy; gnt outputs are 0 while rst_n=0.
REQ-022 SHALL discard any in-flight read on reset: no rvalid follows after rst_n deasserts.
REQ-023 SHALL accept a request in the first clock edge after rst_n deasserts.

Verification
REQ-024 Core read addr 0x0000_0010, ldr idle -> core_gnt cycle N; ram_en=1, ram_addr=4 in N+1; core_rvalid=1 with RAM word 4 in N+2.
REQ-025 core_req and ldr_req held high continuously, MAX_WAIT=4 -> core granted 4 cycles, ldr_gnt in cycle 5, then core again; pattern repeats.
REQ-026 Loader writes 0xDEADBEEF to addr 0x8 then core reads addr 0x8 on the next cycle -> ram_we=1, ram_addr=2 followed by a read of word 2; core_rvalid two cycles after its grant with the value the RAM model returns.
REQ-027 Core read addr 0x0000_0100 (ADDR_W=5) -> ram_en=0, core_rvalid=1 with rdata 0 in N+2, err_cnt=1; 300 such accesses -> err_cnt=255.
REQ-028 Assert rst_n=0 one cycle after a granted read -> busy and ram_en clear asynchronously; no core_rvalid after release; err_cnt=0.
